// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin arbiter sharing one external memory
// controller burst port between the frame write and frame read channels.
// Grants whole bursts, steers controller strobes to the granted channel
// only, and aborts a burst that never finishes via a watchdog.
module mem_burst_arbiter #(
  parameter int ADDR_BITS      = 23,
  parameter int BURST_BITS     = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_BITS        = 13
) (
  input  logic                  mem_clk,
  input  logic                  rst_n,
  input  logic                  wr_burst_req,
  input  logic [BURST_BITS-1:0] wr_burst_len,
  input  logic [ADDR_BITS-1:0]  wr_burst_addr,
  output logic                  wr_burst_data_req,
  output logic                  wr_burst_finish,
  input  logic                  rd_burst_req,
  input  logic [BURST_BITS-1:0] rd_burst_len,
  input  logic [ADDR_BITS-1:0]  rd_burst_addr,
  output logic                  rd_burst_data_valid,
  output logic                  rd_burst_finish,
  output logic                  mem_burst_req,
  output logic                  mem_burst_we,
  output logic [BURST_BITS-1:0] mem_burst_len,
  output logic [ADDR_BITS-1:0]  mem_burst_addr,
  input  logic                  mem_burst_data_req,
  input  logic                  mem_burst_data_valid,
  input  logic                  mem_burst_finish,
  output logic                  timeout_err,
  output logic                  err_sticky,
  output logic [1:0]            grant_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_WR  = 2'd1,
    ST_GNT_RD  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Last watchdog count of a burst; reaching it without finish aborts.
  localparam logic [TO_BITS-1:0] WD_LAST_C = TO_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_BITS-1:0] WD_ONE_C  = TO_BITS'(1);

  state_t                  state_r;
  logic                    last_rd_r;      // 1 = last completed grant was read
  logic [TO_BITS-1:0]      wd_cnt_r;
  logic                    req_r;
  logic                    we_r;
  logic [BURST_BITS-1:0]   len_r;
  logic [ADDR_BITS-1:0]    addr_r;
  logic                    timeout_err_r;  // also marks the synthetic finish cycle
  logic                    err_sticky_r;

  logic                    gnt_wr_s;
  logic                    gnt_rd_s;
  logic                    pick_wr_s;
  logic                    pick_rd_s;
  logic                    wd_expire_s;

  // Decode current owner, watchdog expiry and the round-robin pick
  always_comb begin
    gnt_wr_s    = (state_r == ST_GNT_WR);
    gnt_rd_s    = (state_r == ST_GNT_RD);
    wd_expire_s = (wd_cnt_r == WD_LAST_C);
    if (wr_burst_req && (!rd_burst_req || last_rd_r)) begin
      pick_wr_s = 1'b1;
      pick_rd_s = 1'b0;
    end else if (rd_burst_req) begin
      pick_wr_s = 1'b0;
      pick_rd_s = 1'b1;
    end else begin
      pick_wr_s = 1'b0;
      pick_rd_s = 1'b0;
    end
  end

  // Steer controller strobes to the granted channel; add synthetic finish on abort
  always_comb begin
    wr_burst_data_req   = gnt_wr_s & mem_burst_data_req;
    rd_burst_data_valid = gnt_rd_s & mem_burst_data_valid;
    wr_burst_finish     = (gnt_wr_s & mem_burst_finish) | (timeout_err_r & ~last_rd_r);
    rd_burst_finish     = (gnt_rd_s & mem_burst_finish) | (timeout_err_r & last_rd_r);
  end

  // Arbitration FSM with latched burst command, watchdog and error flags
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      last_rd_r     <= 1'b1;
      wd_cnt_r      <= '0;
      req_r         <= 1'b0;
      we_r          <= 1'b0;
      len_r         <= '0;
      addr_r        <= '0;
      timeout_err_r <= 1'b0;
      err_sticky_r  <= 1'b0;
    end else begin
      timeout_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wd_cnt_r <= '0;
          if (pick_wr_s) begin
            state_r <= ST_GNT_WR;
            req_r   <= 1'b1;
            we_r    <= 1'b1;
            len_r   <= wr_burst_len;
            addr_r  <= wr_burst_addr;
          end else if (pick_rd_s) begin
            state_r <= ST_GNT_RD;
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            len_r   <= rd_burst_len;
            addr_r  <= rd_burst_addr;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT_WR, ST_GNT_RD: begin
          if (mem_burst_finish) begin
            // A finish on the watchdog's last cycle still counts as normal.
            state_r   <= ST_RELEASE;
            req_r     <= 1'b0;
            last_rd_r <= gnt_rd_s;
          end else if (wd_expire_s) begin
            state_r       <= ST_RELEASE;
            req_r         <= 1'b0;
            last_rd_r     <= gnt_rd_s;
            timeout_err_r <= 1'b1;
            err_sticky_r  <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_ONE_C;
          end
        end
        ST_RELEASE: begin
          // One dead cycle lets the finished requester drop its request.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_burst_req  = req_r;
  assign mem_burst_we   = we_r;
  assign mem_burst_len  = len_r;
  assign mem_burst_addr = addr_r;
  assign timeout_err    = timeout_err_r;
  assign err_sticky     = err_sticky_r;
  assign grant_state    = state_r;

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
Shares one single-port external memory controller burst interface between the frame write channel (fifo_write) and the frame read channel (fifo_read). It grants whole bursts using round-robin arbitration and forwards the controller's data_req and finish strobes only to the granted channel. A watchdog aborts hung bursts so that neither requester can lock up. It sits in the mem_clk domain between the channel modules and the controller.

Parameters:
ADDR_BITS, 23, burst address width.
BURST_BITS, 10, burst length width.
TIMEOUT_CYCLES, 4096, max cycles from grant to finish before abort.
TO_BITS, 13, watchdog counter width; must satisfy 2^TO_BITS > TIMEOUT_CYCLES.

Ports:
mem_clk  in  1  memory controller user clock; the only clock.
rst_n  in  1  reset; asynchronous assert, active-low.
wr_burst_req  in  1  write channel request; held high until it sees wr_burst_finish.
wr_burst_len  in  BURST_BITS  write burst length in words.
wr_burst_addr  in  ADDR_BITS  write burst base address.
wr_burst_data_req  out  1  forwarded controller data_req; write grant only.
wr_burst_finish  out  1  forwarded or synthetic finish pulse; write grant only.
rd_burst_req  in  1  read channel request; same hold rule as write.
rd_burst_len  in  BURST_BITS  read burst length.
rd_burst_addr  in  ADDR_BITS  read burst base address.
rd_burst_data_valid  out  1  forwarded controller data_valid; read grant only.
rd_burst_finish  out  1  forwarded or synthetic finish pulse; read grant only.
mem_burst_req  out  1  request to the controller.
mem_burst_we  out  1  1 = write burst, 0 = read burst.
mem_burst_len  out  BURST_BITS  latched length.
mem_burst_addr  out  ADDR_BITS  latched address.
mem_burst_data_req  in  1  controller write-data request.
mem_burst_data_valid  in  1  controller read-data valid.
mem_burst_finish  in  1  controller burst done, 1-cycle pulse.
timeout_err  out  1  1-cycle pulse on watchdog abort.
err_sticky  out  1  set on any abort; cleared only by reset.
grant_state  out  2  current state code, for debug.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - mem_burst_req, mem_burst_we, timeout_err, err_sticky = 0.
  - mem_burst_len = 0, mem_burst_addr = 0.
  - last_grant = RD, so the first tie goes to write.
  - Watchdog counter = 0.
- States and codes: IDLE = 0, GNT_WR = 1, GNT_RD = 2, RELEASE = 3.
- IDLE:
  - Only wr_burst_req high: go to GNT_WR. On the same edge set mem_burst_req = 1, mem_burst_we = 1, and latch wr_burst_len/wr_burst_addr.
  - Only rd_burst_req high: go to GNT_RD with mem_burst_we = 0 and latch the read len/addr.
  - Both high: grant the channel that is not last_grant.
  - Latency from request seen to mem_burst_req high: 1 cycle.
- GNT_x:
  - mem_burst_req stays high, and len/addr stay stable even if the requester's inputs change.
  - data_req/data_valid and finish pass combinationally from the controller to the granted channel. The non-granted channel's strobes are forced to 0.
  - On mem_burst_finish: mem_burst_req = 0 on the next edge, last_grant = x, go to RELEASE.
- RELEASE:
  - Lasts exactly 1 cycle, so the requester can drop its request.
  - Then go to IDLE. A new grant is therefore possible at the earliest 2 cycles after finish.
- Watchdog:
  - The counter clears on entry to GNT_x and increments each cycle in GNT_x.
  - When it reaches TIMEOUT_CYCLES-1 without finish: drop mem_burst_req, pulse timeout_err for 1 cycle, set err_sticky.
  - On the same cycle, drive a synthetic 1-cycle finish to the granted channel, set last_grant = x, and go to RELEASE.
  - Finish and watchdog expiry in the same cycle: treat as a normal finish; no error.
- mem_burst_finish or data strobes arriving in IDLE/RELEASE: ignored, not forwarded.
- A requester dropping its request while granted (not allowed): the burst still completes; the arbiter does not abort.
- Reset asserted mid-burst: all outputs return to reset values immediately and asynchronously. The controller is reset by the same rst_n.
- Requests are level-sensitive. A request still high in IDLE after RELEASE counts as a new request, which gives back-to-back bursts that alternate under contention.
- The err_sticky 0→1 transition occurs only via the watchdog.

Test Plan:
1. Single write: wr_burst_req = 1, len 64, addr 0x1000; controller returns finish 70 cycles later → mem_burst_req rises 1 cycle after the request with we = 1, len 64, addr 0x1000; wr_burst_finish pulses once; rd_burst_finish stays 0; state passes 0→1→3→0.
2. Simultaneous requests straight after reset, both held through 4 bursts → grant order WR, RD, WR, RD; each new mem_burst_req rises 2 cycles after the previous finish.
3. Data routing during a read grant: pulse mem_burst_data_req and mem_burst_data_valid → only rd_burst_data_valid follows; wr_burst_data_req stays 0 throughout.
4. Hung burst: grant write, never finish → mem_burst_req drops, timeout_err and wr_burst_finish pulse together once the watchdog counter reaches 4095 (count cleared on grant entry, incremented each GNT cycle); err_sticky stays 1; a following read request is granted normally.
5. Finish on the watchdog's final cycle → no timeout_err pulse, err_sticky stays 0.
6. Assert rst_n low mid-read-burst with addr 0x2000 → mem_burst_req, mem_burst_addr, and grant_state read 0 before the next mem_clk edge; after release the first tie goes to write.
